div_64: RTL and testbench
=========================

DIV_64 -- requirements
Module: div_64

Interface
REQ-001 Parameters: none; width fixed at 64 bits, iteration count fixed at 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 init_in  input  1  start request; level may be held high for several cycles.
REQ-005 A  input  64  unsigned dividend.
REQ-006 B  input  64  unsigned divisor.
REQ-007 Result  output  64  unsigned quotient floor(A/B), registered.
REQ-008 busy  output  1  high while a division is in progress.

Function
REQ-009 The block SHALL compute the unsigned integer quotient floor(A/B) by restoring shift-subtract division, one quotient bit per clock, MSB first.
REQ-010 The block SHALL have two states: IDLE and RUN.
REQ-011 A start SHALL occur on a clock edge where init_in=1, the previous-cycle init_in=0 (rising edge), and the state is IDLE.
REQ-012 On start, the block SHALL capture A and B into internal registers, clear the 64-bit partial remainder, load a 7-bit iteration counter with 64, set busy=1 and enter RUN.
REQ-013 A and B SHALL be sampled only at start; changes during RUN SHALL be ignored.
REQ-014 Each RUN cycle: {rem,dividend} shifts left one bit; if the 65-bit shifted remainder >= B, subtract B and shift in quotient bit 1, else shift in 0; decrement the counter.
REQ-015 After exactly 64 RUN cycles, the block SHALL load Result with the quotient, clear busy and return to IDLE on the same edge.
REQ-016 busy SHALL be high for exactly 64 consecutive cycles per operation, starting the cycle after the start edge.
REQ-017 Result SHALL hold its previous value throughout RUN and until the next operation completes; Result and busy SHALL never change in IDLE except on reset.
REQ-018 init_in held high through an entire operation SHALL NOT start a second operation; a new rising edge after return to IDLE is required.
REQ-019 Rising edges of init_in during RUN SHALL be ignored (no queuing).
REQ-020 B=0 SHALL produce Result = 64'hFFFF_FFFF_FFFF_FFFF with normal 64-cycle latency; no error flag.
REQ-021 A<B SHALL produce Result=0; A=B (B!=0) SHALL produce Result=1.
REQ-022 Intermediate remainder comparison SHALL use 65 bits so no carry is lost when the divisor MSB is set.

Reset
REQ-023 When rst=1 at a clock edge: state=IDLE, busy=0, Result=0, counter, remainder, captured operands and the init_in edge-detect register all cleared.
REQ-024 Reset asserted during RUN SHALL abort the operation; Result SHALL read 0, not a partial quotient.
REQ-025 rst SHALL take priority over a simultaneous start request.

Structure
REQ-026 A shared package SHALL hold the data-width constant (64), the iteration-count constant (64) and the state enumeration {IDLE, RUN}.
REQ-027 The design SHALL be a single module; no sub-module is required. The 65-bit compare/subtract SHALL remain inline combinational logic.

Verification
REQ-028 Reset: rst=1 for 10 cycles -> busy=0, Result=0; no start is taken while rst=1 even if init_in=1.
REQ-029 A=8835<<32, B=100000000, init_in high for 4 cycles -> busy high for exactly 64 cycles, then Result=379460.
REQ-030 Back-to-back: on busy fall, wait 5 cycles; A=289505280<<32, B=100000000, pulse init_in -> Result=12434157096; Result holds 379460 until completion.
REQ-031 Corner operands -> B=0 gives all-ones; A=5,B=7 gives 0; A=B=64'hFFFF_FFFF_FFFF_FFFF gives 1; A=64'hFFFF_FFFF_FFFF_FFFF, B=1 gives all-ones; B=64'h8000_0000_0000_0000, A=all-ones gives 1.
REQ-032 init_in held high for 200 cycles -> exactly one operation; busy stays low after completion; A/B changed mid-RUN do not affect Result.
REQ-033 rst pulsed at RUN cycle 30 -> busy=0 and Result=0 next cycle; a subsequent new start yields a correct quotient.

Source files
------------

// File: rtl/div_64_pkg.sv
// Shared constants and state encoding for the 64-bit restoring divider.
//   DATA_W     : operand / quotient width
//   ITER_COUNT : number of shift-subtract iterations per division
//   CNT_W      : width of the iteration counter (must hold ITER_COUNT)
//   state_t    : controller states {IDLE, RUN}
package div_64_pkg;

   localparam int DATA_W     = 64;
   localparam int ITER_COUNT = 64;
   localparam int CNT_W      = 7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : div_64_pkg

// File: rtl/div_64.sv
// Unsigned 64-bit restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk     : clock, all state updates on the rising edge
//   rst     : synchronous active-high reset
//   init_in : start request, acted on at its rising edge while IDLE only
//   A       : unsigned dividend, sampled at start
//   B       : unsigned divisor, sampled at start (B=0 yields all ones)
//   Result  : registered quotient floor(A/B), updated only on completion
//   busy    : high for exactly 64 cycles while a division runs
module div_64
   import div_64_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              init_in,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] Result,
   output logic              busy
);

   localparam logic [CNT_W-1:0] ITER_LOAD = CNT_W'(ITER_COUNT);

   state_t            state_reg;
   logic              init_prev_reg;
   logic [DATA_W-1:0] dividend_reg;   // shifts out dividend bits, shifts in quotient bits
   logic [DATA_W-1:0] divisor_reg;
   logic [DATA_W-1:0] rem_reg;
   logic [CNT_W-1:0]  count_reg;

   logic [DATA_W:0]   shifted_rem;
   logic [DATA_W-1:0] rem_next;
   logic [DATA_W-1:0] quot_next;
   logic              q_bit;
   logic              start;

   assign start = init_in && !init_prev_reg && (state_reg == IDLE);

   // One restoring step. The shifted remainder is kept at 65 bits so that a
   // carry out of bit 63 is not lost when the divisor has its MSB set; the
   // difference always fits back into 64 bits because it is below the divisor.
   always_comb begin
      shifted_rem = {rem_reg, dividend_reg[DATA_W-1]};
      q_bit       = 1'b0;
      rem_next    = shifted_rem[DATA_W-1:0];
      if (shifted_rem >= {1'b0, divisor_reg}) begin
         q_bit    = 1'b1;
         rem_next = shifted_rem[DATA_W-1:0] - divisor_reg;
      end
      quot_next = {dividend_reg[DATA_W-2:0], q_bit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         init_prev_reg <= 1'b0;
         dividend_reg  <= '0;
         divisor_reg   <= '0;
         rem_reg       <= '0;
         count_reg     <= '0;
         Result        <= '0;
         busy          <= 1'b0;
      end else begin
         init_prev_reg <= init_in;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  dividend_reg <= A;
                  divisor_reg  <= B;
                  rem_reg      <= '0;
                  count_reg    <= ITER_LOAD;
                  busy         <= 1'b1;
                  state_reg    <= RUN;
               end
            end
            RUN: begin
               dividend_reg <= quot_next;
               rem_reg      <= rem_next;
               count_reg    <= count_reg - 1'b1;
               // Last iteration: publish the quotient on the same edge.
               if (count_reg == CNT_W'(1)) begin
                  Result    <= quot_next;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule : div_64

// File: tb/tb_div_64.sv
// Self-checking bench for div_64: directed and random divisions checked
// against a plain-arithmetic quotient model, plus reset behaviour.
module tb_div_64;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_in;
   logic [63:0] A;
   logic [63:0] B;
   logic [63:0] Result;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_prev;
   logic [63:0] ALL_ONES;

   div_64 dut (
      .clk     (clk),
      .rst     (rst),
      .init_in (init_in),
      .A       (A),
      .B       (B),
      .Result  (Result),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [63:0] model_div(input logic [63:0] a, input logic [63:0] b);
      if (b == 64'd0) return {64{1'b1}};
      return a / b;
   endfunction

   // Runs one division. init_in is held high for 'hold' cycles; A/B are
   // scrambled mid-run; Result must hold 'exp_prev' while busy.
   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input int hold, input logic [63:0] exp_q);
      int cyc        = 0;
      int busy_cnt   = 0;
      int first_busy = -1;
      bit hold_bad   = 1'b0;
      @(negedge clk);
      A = a; B = b; init_in = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc >= hold) init_in = 1'b0;
         if (cyc == 10) begin
            A = {$urandom, $urandom};
            B = {$urandom, $urandom};
         end
         if (busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
            if (Result !== exp_prev) hold_bad = 1'b1;
         end
      end while ((busy || cyc < 2) && cyc < 300);
      check_val({tag, "_busy_len"}, 64'(busy_cnt), 64'd64);
      check_val({tag, "_busy_start"}, 64'(first_busy), 64'd1);
      check_val({tag, "_hold"}, 64'(hold_bad), 64'd0);
      check_val({tag, "_result"}, Result, exp_q);
      // init_in still high after completion must not restart.
      while (cyc < hold) begin
         @(negedge clk);
         cyc++;
         if (busy) hold_bad = 1'b1;
      end
      if (hold > 1) check_val({tag, "_no_restart"}, 64'(hold_bad), 64'd0);
      init_in = 1'b0;
      $display("op %s: A=0x%h B=0x%h Result=0x%h busy_cycles=%0d", tag, a, b, Result, busy_cnt);
      exp_prev = exp_q;
   endtask

   initial begin
      logic [63:0] ra, rb;
      ALL_ONES = {64{1'b1}};
      rst = 1'b1; init_in = 1'b0; A = '0; B = '0;
      exp_prev = '0;

      // Reset: start requests during reset are ignored.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         init_in = (i == 3 || i == 4 || i == 7);
         A = 64'd100; B = 64'd3;
      end
      check_val("rst_busy", {63'd0, busy}, 64'd0);
      check_val("rst_result", Result, 64'd0);
      init_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_val("post_rst_idle", {63'd0, busy}, 64'd0);

      // Directed values with init_in held for 4 cycles, then back-to-back.
      run_op("dir1", 64'd8835 << 32, 64'd100000000, 4, 64'd379460);
      repeat (5) @(negedge clk);
      run_op("dir2", 64'd289505280 << 32, 64'd100000000, 1, 64'd12434157096);

      // Corner operands.
      run_op("b_zero", 64'd12345, 64'd0, 1, ALL_ONES);
      run_op("a_lt_b", 64'd5, 64'd7, 1, 64'd0);
      run_op("a_eq_b", ALL_ONES, ALL_ONES, 1, 64'd1);
      run_op("b_one", ALL_ONES, 64'd1, 1, ALL_ONES);
      run_op("b_msb", ALL_ONES, 64'h8000_0000_0000_0000, 1, 64'd1);

      // Long init_in level: exactly one operation.
      run_op("hold200", 64'd1_000_000_007, 64'd13, 200, model_div(64'd1_000_000_007, 64'd13));

      // Random operands, divisor width varied.
      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(63, 0);
         run_op($sformatf("rand%0d", i), ra, rb, 1, model_div(ra, rb));
      end

      // Reset in the middle of a run aborts it and clears Result.
      @(negedge clk);
      A = 64'd999_999_999_999; B = 64'd7; init_in = 1'b1;
      @(negedge clk);
      init_in = 1'b0;
      repeat (29) @(negedge clk);
      check_val("mid_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_busy", {63'd0, busy}, 64'd0);
      check_val("abort_result", Result, 64'd0);
      rst = 1'b0;
      exp_prev = '0;
      $display("op abort: reset at run cycle 30, Result=0x%h", Result);
      ra = {$urandom, $urandom};
      rb = 64'({$urandom} | 32'd1);
      run_op("after_abort", ra, rb, 1, model_div(ra, rb));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_div_64
